// File: rtl/i2c_target.sv
// i2c_target -- I2C target (slave) responder.
//
// Oversamples raw SCL/SDA on clk, detects START/STOP, matches a 7-bit
// address and then either delivers written bytes (rx_data/rx_valid) or
// fetches bytes to return (tx_req/tx_data) and shifts them out open-drain.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   scl_in     raw bus SCL
//   sda_in     raw bus SDA
//   sda_oe     1 = pull SDA low, 0 = release
//   rx_data    last byte written by the master
//   rx_valid   one-cycle strobe, rx_data valid
//   tx_data    byte to return on read, sampled while tx_req is high
//   tx_req     one-cycle strobe requesting the next read byte
//   addressed  high from address ACK until STOP/START
//   busy       high from START until STOP
//
// Build option: define I2C_TGT_GLITCH_FILTER_EN to insert a 3-sample
// hold filter on each synchronized line (rejects 1-2 clk spikes, +2 clk
// edge latency).

module i2c_target #(
  parameter logic [6:0]  ADDR        = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WRITE,
    ST_WRITE_ACK, ST_READ, ST_READ_ACK, ST_WAIT_STOP
  } state_t;

  // Synchronizers, preset to the idle-bus level.
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_s, sda_s, scl_line, sda_line;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_TGT_GLITCH_FILTER_EN
  // hist[0] is one clk old, hist[1] two clk old. The filtered line follows
  // the synced sample only when all three agree, otherwise holds.
  logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_hold_q, sda_hold_q;

  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_s};
    sda_hist_d = {sda_hist_q[0], sda_s};
    scl_line   = (scl_s == scl_hist_q[0] && scl_s == scl_hist_q[1]) ? scl_s : scl_hold_q;
    sda_line   = (sda_s == sda_hist_q[0] && sda_s == sda_hist_q[1]) ? sda_s : sda_hold_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_hold_q <= 1'b1;
      sda_hold_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_hold_q <= scl_line;
      sda_hold_q <= sda_line;
    end
  end
`else
  always_comb begin
    scl_line = scl_s;
    sda_line = sda_s;
  end
`endif

  assign scl_prev_d = scl_line;
  assign sda_prev_d = sda_line;

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_line & ~scl_prev_q;
  assign scl_fall  = ~scl_line & scl_prev_q;
  assign start_det = ~sda_line & sda_prev_q & scl_line;
  assign stop_det  = sda_line & ~sda_prev_q & scl_line;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
  logic       rw_q, rw_d, sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d;
  logic       addressed_q, addressed_d, busy_q, busy_d, tx_load;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    rx_valid_d  = 1'b0;
    addressed_d = addressed_q;
    busy_d      = busy_q;
    tx_load     = 1'b0;

    if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = '0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b1;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_line};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == ADDR) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d  = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            addressed_d = 1'b1;
            if (rw_q) begin
              tx_load = 1'b1;
              state_d = ST_READ;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_line};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = {shift_q[6:0], sda_line};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = ST_WRITE_ACK;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WRITE;
          end
        end
        ST_READ: begin
          // bit_cnt counts bits already placed on the bus.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_READ_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_READ_ACK: begin
          // A NACK leaves on the rise; a fall here therefore follows an ACK.
          if (scl_rise && sda_line) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall) begin
            tx_load = 1'b1;
            state_d = ST_READ;
          end
        end
        default: ;
      endcase

      if (tx_load) begin
        sda_oe_d   = ~tx_data[7];
        tx_shift_d = {tx_data[6:0], 1'b0};
        bit_cnt_d  = 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      rx_valid_q  <= rx_valid_d;
      addressed_q <= addressed_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_load;
  assign addressed = addressed_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target -- directed self-checking bench for i2c_target.
// Drives a bit-banged master (SCL quarter period = 8 clk) onto an
// open-drain bus model and checks ACKs, read data, strobes and status.

module tb_i2c_target;

  localparam int unsigned Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in, sda_oe, rx_valid, tx_req, addressed, busy;
  logic [7:0] rx_data, tx_data;

  int total = 0;
  int bad   = 0;

  int         rx_cnt = 0, tx_cnt = 0, both_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  always #5 clk = ~clk;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .addressed(addressed), .busy(busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      rx_last <= rx_data;
    end
    if (tx_req) tx_cnt <= tx_cnt + 1;
    if (rx_valid && tx_req) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  // One SCL clock; oe is the target's sda_oe sampled mid high phase.
  task automatic bit_cycle(input logic b, output logic oe);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    oe = sda_oe;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_oe);
    logic dummy;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], dummy);
    bit_cycle(1'b1, ack_oe);
  endtask

  task automatic read_byte(input logic m_ack, input logic [7:0] next_tx,
                           output logic [7:0] data, output logic slot_oe);
    logic oe;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, oe);
      data = {data[6:0], ~oe};
    end
    tx_data = next_tx;
    bit_cycle(~m_ack, slot_oe);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       ack, slot, seen;
    logic [7:0] d;
    int         rx0, tx0;

    tx_data = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    check("rst_addressed", {31'd0, addressed}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 1-clk SDA spike while SCL high
    seen = 1'b0;
    sda_m = 1'b0; @(negedge clk);
    sda_m = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | busy;
    end
`ifdef I2C_TGT_GLITCH_FILTER_EN
    check("glitch_busy", {31'd0, seen}, 32'd0);
`else
    check("glitch_busy", {31'd0, seen}, 32'd1);
`endif
    check("glitch_end_busy", {31'd0, busy}, 32'd0);

    // Write 0xA5 to 0x42
    rx0 = rx_cnt;
    i2c_start();
    check("wr_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h84, ack);
    check("wr_addr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'hA5, ack);
    check("wr_data_ack", {31'd0, ack}, 32'd1);
    check("wr_addressed", {31'd0, addressed}, 32'd1);
    i2c_stop();
    check("wr_rx_count", rx_cnt - rx0, 32'd1);
    check("wr_rx_data", {24'd0, rx_last}, 32'hA5);
    check("wr_addressed_stop", {31'd0, addressed}, 32'd0);
    check("wr_busy_stop", {31'd0, busy}, 32'd0);

    // Wrong address 0x43
    rx0 = rx_cnt; tx0 = tx_cnt;
    i2c_start();
    send_byte(8'h86, ack);
    check("wa_no_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h00, ack);
    check("wa_no_ack2", {31'd0, ack}, 32'd0);
    check("wa_addressed", {31'd0, addressed}, 32'd0);
    i2c_stop();
    check("wa_rx_count", rx_cnt - rx0, 32'd0);
    check("wa_tx_count", tx_cnt - tx0, 32'd0);
    check("wa_busy", {31'd0, busy}, 32'd0);

    // Read 0x3C (ACK) then 0xC3 (NACK)
    tx0 = tx_cnt;
    tx_data = 8'h3C;
    i2c_start();
    send_byte(8'h85, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    check("rd_tx_req1", tx_cnt - tx0, 32'd1);
    read_byte(1'b1, 8'hC3, d, slot);
    check("rd_byte0", {24'd0, d}, 32'h3C);
    check("rd_slot0_released", {31'd0, slot}, 32'd0);
    read_byte(1'b0, 8'h00, d, slot);
    check("rd_byte1", {24'd0, d}, 32'hC3);
    check("rd_slot1_released", {31'd0, slot}, 32'd0);
    check("rd_sda_after_nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    check("rd_tx_req_total", tx_cnt - tx0, 32'd2);
    check("rd_busy", {31'd0, busy}, 32'd0);

    // Write 0x11, repeated START, read 0x96
    rx0 = rx_cnt; tx0 = tx_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h11, ack);
    check("rs_wr_ack", {31'd0, ack}, 32'd1);
    check("rs_addressed_pre", {31'd0, addressed}, 32'd1);
    tx_data = 8'h96;
    i2c_start();
    check("rs_addressed_sr", {31'd0, addressed}, 32'd0);
    check("rs_busy_sr", {31'd0, busy}, 32'd1);
    check("rs_tx_before", tx_cnt - tx0, 32'd0);
    send_byte(8'h85, ack);
    check("rs_rd_ack", {31'd0, ack}, 32'd1);
    check("rs_addressed_post", {31'd0, addressed}, 32'd1);
    check("rs_tx_req", tx_cnt - tx0, 32'd1);
    read_byte(1'b0, 8'h00, d, slot);
    check("rs_rd_byte", {24'd0, d}, 32'h96);
    i2c_stop();
    check("rs_rx_data", {24'd0, rx_last}, 32'h11);
    check("rs_rx_count", rx_cnt - rx0, 32'd1);

    // Reset while driving a read bit
    tx_data = 8'h00;
    i2c_start();
    send_byte(8'h85, ack);
    check("rr_driving", {31'd0, sda_oe}, 32'd1);
    rst = 1'b0;
    #1;
    check("rr_async_oe", {31'd0, sda_oe}, 32'd0);
    check("rr_async_busy", {31'd0, busy}, 32'd0);
    check("rr_async_addr", {31'd0, addressed}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    i2c_stop();
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    check("rr_addr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h5A, ack);
    check("rr_data_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("rr_rx_data", {24'd0, rx_last}, 32'h5A);
    check("rr_rx_count", rx_cnt - rx0, 32'd1);

    check("strobe_overlap", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
